// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-addressed, negedge-sampled data memory.
// Sub-word stores use read-modify-write; sub-word loads are lane-extracted and extended.
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  state_t      state, state_n;
  logic [1:0]  size_q, size_n;
  logic        uns_q, uns_n;
  logic [1:0]  lane_q, lane_n;
  logic [15:0] wlo_q, wlo_n;
  logic        ready_n, done_n, err_n, rd_n, wr_n;
  logic [31:0] rdata_n, maddr_n, mwd_n;
  logic        bad;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {ln, 3'b000});
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = {{24{b[7] & ~u}}, b};
      2'b01:   load_ext = {{16{h[15] & ~u}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] ln, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00)  m[{ln, 3'b000} +: 8] = d[7:0];
    else if (ln[1])   m[31:16] = d;
    else              m[15:0]  = d;
    merge = m;
  endfunction

  always_comb begin
    bad = (size == 2'b11) ||
          (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) ||
          (addr >= MEM_BYTES);
  end

  // Every output is computed here as a next value and registered below.
  always_comb begin
    state_n = state;
    size_n  = size_q;
    uns_n   = uns_q;
    lane_n  = lane_q;
    wlo_n   = wlo_q;
    ready_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    rdata_n = rdata;
    maddr_n = memAddress;
    mwd_n   = memWriteData;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (req) begin
          ready_n = 1'b0;
          size_n  = size;
          uns_n   = uns;
          lane_n  = addr[1:0];
          wlo_n   = wdata[15:0];
          maddr_n = {addr[31:2], 2'b00};
          if (bad) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
            rdata_n = '0;
          end else if (!we) begin
            state_n = RD;
            rd_n    = 1'b1;
          end else if (size == 2'b10) begin
            state_n = WR;
            wr_n    = 1'b1;
            mwd_n   = wdata;
          end else begin
            state_n = RMW_RD;
            rd_n    = 1'b1;
          end
        end
      end
      RD: begin
        rdata_n = load_ext(memReadData, size_q, lane_q, uns_q);
        done_n  = 1'b1;
        state_n = DONE;
      end
      WR: begin
        done_n  = 1'b1;
        state_n = DONE;
      end
      RMW_RD: begin
        mwd_n   = merge(memReadData, size_q, lane_q, wlo_q);
        wr_n    = 1'b1;
        state_n = RMW_WR;
      end
      RMW_WR: begin
        done_n  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: begin
        ready_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      wlo_q        <= '0;
      ready        <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
    end else begin
      state        <= state_n;
      size_q       <= size_n;
      uns_q        <= uns_n;
      lane_q       <= lane_n;
      wlo_q        <= wlo_n;
      ready        <= ready_n;
      done         <= done_n;
      err          <= err_n;
      rdata        <= rdata_n;
      memRead      <= rd_n;
      memWrite     <= wr_n;
      memAddress   <= maddr_n;
      memWriteData <= mwd_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a negedge-sampled word memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err, memRead, memWrite;
  logic [31:0] rdata, memAddress, memWriteData, memReadData;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] rd_word = '0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWrite) mem[memAddress[15:2]] <= memWriteData;
    if (memRead)  rd_word <= mem[memAddress[15:2]];
  end
  assign memReadData = rd_word;

  mem_access_ctrl #(.MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .memAddress(memAddress), .memWriteData(memWriteData),
    .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData)
  );

  // Issues one request, then scrambles the inputs to show they were latched.
  // lat/rdc/wrc are cycle indices after the accepting edge (99/0 = not seen).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int rdc, output int wrc, output logic both,
                        output logic [31:0] wd, output logic [31:0] ma,
                        output logic [31:0] rd, output logic e);
    int waitc;
    lat = 99; rdc = 0; wrc = 0; both = 1'b0; wd = '0; ma = '0; rd = '0; e = 1'b0;
    waitc = 0;
    @(negedge clk);
    while (!ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; size = 2'b11; uns = ~u; addr = 32'h30; wdata = '0;
    for (int k = 1; k <= 10; k++) begin
      if (memRead && rdc == 0) rdc = k;
      if (memWrite && wrc == 0) begin
        wrc = k;
        wd  = memWriteData;
      end
      if (memRead && memWrite) both = 1'b1;
      if (k == 1) ma = memAddress;
      if (done) begin
        lat = k;
        rd  = rdata;
        e   = err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else passes++;
    checks++; if ({done, err, memRead, memWrite} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {done, err, memRead, memWrite}); else passes++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passes++;
    checks++; if ({memAddress, memWriteData} !== 64'h0)
      $display("FAIL reset_membus got=%h exp=0", {memAddress, memWriteData}); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word;
    int lat, rdc, wrc; logic both, e; logic [31:0] wd, ma, rd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (lat !== 2) $display("FAIL wst_latency got=%0d exp=2", lat); else passes++;
    checks++; if (rdc !== 0 || wrc !== 1)
      $display("FAIL wst_strobes got rd=%0d wr=%0d exp rd=0 wr=1", rdc, wrc); else passes++;
    checks++; if (wd !== 32'hDEADBEEF || ma !== 32'h10)
      $display("FAIL wst_bus got data=%h addr=%h exp data=deadbeef addr=10", wd, ma); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL wst_err got=%b exp=0", e); else passes++;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (lat !== 2 || rdc !== 1 || wrc !== 0)
      $display("FAIL wld_timing got lat=%0d rd=%0d wr=%0d exp 2/1/0", lat, rdc, wrc); else passes++;
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0)
      $display("FAIL wld_data got=%h err=%b exp=deadbeef err=0", rd, e); else passes++;
    checks++; if (ready !== 1'b0) $display("FAIL ready_during_done got=%b exp=0", ready); else passes++;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0)
      $display("FAIL ready_after_done got ready=%b done=%b exp 1/0", ready, done); else passes++;
    checks++; if (rdata !== 32'hDEADBEEF)
      $display("FAIL rdata_held got=%h exp=deadbeef", rdata); else passes++;
  endtask

  task automatic test_byte_store;
    int lat, rdc, wrc; logic both, e; logic [31:0] wd, ma, rd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rdc, wrc, both, wd, ma, rd, e);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (lat !== 3) $display("FAIL bst_latency got=%0d exp=3", lat); else passes++;
    checks++; if (rdc !== 1 || wrc !== 2 || both !== 1'b0)
      $display("FAIL bst_strobes got rd=%0d wr=%0d both=%b exp 1/2/0", rdc, wrc, both); else passes++;
    checks++; if (wd !== 32'h11225A44)
      $display("FAIL bst_merge got=%h exp=11225a44", wd); else passes++;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'h11225A44) $display("FAIL bst_readback got=%h exp=11225a44", rd); else passes++;
  endtask

  task automatic test_byte_load;
    int lat, rdc, wrc; logic both, e; logic [31:0] wd, ma, rd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000, lat, rdc, wrc, both, wd, ma, rd, e);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'hFFFFFF80 || lat !== 2)
      $display("FAIL bld_signed got=%h lat=%0d exp=ffffff80 lat=2", rd, lat); else passes++;
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'h00000080) $display("FAIL bld_unsigned got=%h exp=00000080", rd); else passes++;
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'h00000000) $display("FAIL bld_lane1 got=%h exp=00000000", rd); else passes++;
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'hFFFFFFFF) $display("FAIL bld_lane2 got=%h exp=ffffffff", rd); else passes++;
  endtask

  task automatic test_half;
    int lat, rdc, wrc; logic both, e; logic [31:0] wd, ma, rd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001FFFF, lat, rdc, wrc, both, wd, ma, rd, e);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'hFFFF8001) $display("FAIL hld_signed got=%h exp=ffff8001", rd); else passes++;
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'h00008001) $display("FAIL hld_unsigned got=%h exp=00008001", rd); else passes++;
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (rd !== 32'hFFFFFFFF) $display("FAIL hld_low got=%h exp=ffffffff", rd); else passes++;
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (wd !== 32'h1234FFFF || lat !== 3)
      $display("FAIL hst_merge got=%h lat=%0d exp=1234ffff lat=3", wd, lat); else passes++;
  endtask

  task automatic test_errors;
    int lat, rdc, wrc; logic both, e; logic [31:0] wd, ma, rd;
    logic        ew  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  esz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] ead [4] = '{32'h21, 32'h22, 32'h10, 32'h10000};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
      do_req(ew[i], esz[i], 1'b0, ead[i], 32'hCAFEF00D, lat, rdc, wrc, both, wd, ma, rd, e);
      checks++; if (lat !== 1 || e !== 1'b1)
        $display("FAIL err%0d_flag got lat=%0d err=%b exp lat=1 err=1", i, lat, e); else passes++;
      checks++; if (rdc !== 0 || wrc !== 0)
        $display("FAIL err%0d_strobes got rd=%0d wr=%0d exp 0/0", i, rdc, wrc); else passes++;
      checks++; if (rd !== 32'h0) $display("FAIL err%0d_rdata got=%h exp=0", i, rd); else passes++;
    end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFC, 32'h0BADCAFE, lat, rdc, wrc, both, wd, ma, rd, e);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFC, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (e !== 1'b0 || rd !== 32'h0BADCAFE)
      $display("FAIL top_word got=%h err=%b exp=0badcafe err=0", rd, e); else passes++;
  endtask

  task automatic test_reset_mid;
    int lat, rdc, wrc; logic both, e; logic [31:0] wd, ma, rd;
    logic seen_done;
    int waitc;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h76543210, lat, rdc, wrc, both, wd, ma, rd, e);
    waitc = 0;
    @(negedge clk);
    while (!ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h11; wdata = 32'h77;
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (memRead !== 1'b1) $display("FAIL mid_rmw_read got=%b exp=1", memRead); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (memRead !== 1'b0 || memWrite !== 1'b0 || ready !== 1'b1)
      $display("FAIL mid_async got rd=%b wr=%b ready=%b exp 0/0/1", memRead, memWrite, ready); else passes++;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) $display("FAIL mid_no_done got=%b exp=0", seen_done); else passes++;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rdc, wrc, both, wd, ma, rd, e);
    checks++; if (lat !== 2 || rd !== 32'h76543210 || e !== 1'b0)
      $display("FAIL post_reset_load got=%h lat=%0d err=%b exp=76543210 lat=2 err=0", rd, lat, e); else passes++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_store();
    test_byte_load();
    test_half();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
